queue_arbiter: RTL and testbench

- Controller that sits in front of the 8-deep byte queue and shares it between two producers and one consumer.
- Round-robin arbitration between producers for enqueue slots; consumer pops have priority.
- Issues at most one queue operation at a time and keeps a shadow occupancy count, so it never enqueues when full or dequeues when empty.
- Sticky error flag when the queue's is_empty/is_full flags disagree with the shadow count.

---
 rtl/queue_arbiter.sv | 142 ++++++++++++++
 tb/tb_queue_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/queue_arbiter.sv
// queue_arbiter: shares one byte queue between two round-robin producers and
// one consumer. Only one queue operation is issued at a time, and a shadow
// occupancy count stops enqueues when the queue is full and dequeues when it
// is empty. err is set and held when the queue flags disagree with that count.
module queue_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int LVL_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  p0_req,
  input  logic [DATA_WIDTH-1:0] p0_data,
  output logic                  p0_gnt,
  input  logic                  p1_req,
  input  logic [DATA_WIDTH-1:0] p1_data,
  output logic                  p1_gnt,
  input  logic                  c_req,
  output logic                  c_valid,
  output logic [DATA_WIDTH-1:0] c_data,
  output logic [LVL_W-1:0]      level,
  output logic                  err,
  output logic                  q_rst,
  output logic                  q_enqueue,
  output logic                  q_dequeue,
  output logic                  q_peek,
  output logic [DATA_WIDTH-1:0] q_data_in,
  input  logic [DATA_WIDTH-1:0] q_data_out,
  input  logic                  q_is_empty,
  input  logic                  q_is_full
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, RD_WAIT} state_t;

  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);

  state_t                state_q, state_d;
  logic                  rr_q, rr_d;          // 1: p1 was granted last
  logic [LVL_W-1:0]      level_q, level_d;
  logic                  err_q, err_d;
  logic                  p0_gnt_q, p0_gnt_d;
  logic                  p1_gnt_q, p1_gnt_d;
  logic                  c_valid_q, c_valid_d;
  logic [DATA_WIDTH-1:0] c_data_q, c_data_d;
  logic                  enq_q, enq_d;
  logic                  deq_q, deq_d;
  logic [DATA_WIDTH-1:0] data_in_q, data_in_d;
  logic                  win_p1;

  // p1 wins if it is the only requester, or on a tie when p0 was granted last
  assign win_p1 = p1_req && (!p0_req || !rr_q);

  // Next-state and registered-output decode
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    level_d   = level_q;
    err_d     = err_q;
    p0_gnt_d  = 1'b0;
    p1_gnt_d  = 1'b0;
    c_valid_d = 1'b0;
    c_data_d  = c_data_q;
    enq_d     = 1'b0;
    deq_d     = 1'b0;
    data_in_d = data_in_q;
    case (state_q)
      IDLE: begin
        if (((level_q == '0) != q_is_empty) || ((level_q == LVL_FULL) != q_is_full)) begin
          err_d = 1'b1;
        end
        if (c_req && (level_q != '0)) begin
          state_d = READ;
          deq_d   = 1'b1;
        end else if ((p0_req || p1_req) && (level_q != LVL_FULL)) begin
          state_d   = WRITE;
          enq_d     = 1'b1;
          rr_d      = win_p1;
          p0_gnt_d  = !win_p1;
          p1_gnt_d  = win_p1;
          data_in_d = win_p1 ? p1_data : p0_data;
        end
      end
      WRITE: begin
        level_d = level_q + LVL_ONE;
        state_d = IDLE;
      end
      READ: begin
        level_d = level_q - LVL_ONE;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        c_data_d  = q_data_out;
        c_valid_d = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any operation in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      rr_q      <= 1'b1;
      level_q   <= '0;
      err_q     <= 1'b0;
      p0_gnt_q  <= 1'b0;
      p1_gnt_q  <= 1'b0;
      c_valid_q <= 1'b0;
      c_data_q  <= '0;
      enq_q     <= 1'b0;
      deq_q     <= 1'b0;
      data_in_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      level_q   <= level_d;
      err_q     <= err_d;
      p0_gnt_q  <= p0_gnt_d;
      p1_gnt_q  <= p1_gnt_d;
      c_valid_q <= c_valid_d;
      c_data_q  <= c_data_d;
      enq_q     <= enq_d;
      deq_q     <= deq_d;
      data_in_q <= data_in_d;
    end
  end

  assign p0_gnt    = p0_gnt_q;
  assign p1_gnt    = p1_gnt_q;
  assign c_valid   = c_valid_q;
  assign c_data    = c_data_q;
  assign level     = level_q;
  assign err       = err_q;
  assign q_enqueue = enq_q;
  assign q_dequeue = deq_q;
  assign q_data_in = data_in_q;
  assign q_rst     = ~rst;
  assign q_peek    = 1'b0;

endmodule

// File: tb/tb_queue_arbiter.sv
// Testbench for queue_arbiter: directed scenarios against a behavioural 8-deep queue.
module tb_queue_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       p0_req = 1'b0, p1_req = 1'b0, c_req = 1'b0;
  logic [7:0] p0_data = '0, p1_data = '0;
  logic       p0_gnt, p1_gnt, c_valid, err, q_rst, q_enqueue, q_dequeue, q_peek;
  logic [7:0] c_data, q_data_in, q_data_out;
  logic [3:0] level;
  logic       q_is_empty, q_is_full;
  logic       force_empty = 1'b0;

  int checks = 0;
  int errors = 0;
  int viol   = 0;

  always #5 clk = ~clk;

  queue_arbiter #(.DATA_WIDTH(8), .DEPTH(8), .LVL_W(4)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_data(p0_data), .p0_gnt(p0_gnt),
    .p1_req(p1_req), .p1_data(p1_data), .p1_gnt(p1_gnt),
    .c_req(c_req), .c_valid(c_valid), .c_data(c_data),
    .level(level), .err(err), .q_rst(q_rst),
    .q_enqueue(q_enqueue), .q_dequeue(q_dequeue), .q_peek(q_peek),
    .q_data_in(q_data_in), .q_data_out(q_data_out),
    .q_is_empty(q_is_empty), .q_is_full(q_is_full)
  );

  // Behavioural queue: data_out valid the cycle after a dequeue
  logic [7:0]  qmem [8];
  int unsigned qwp = 0, qrp = 0, qcnt = 0;
  logic [7:0]  qdo = '0;

  always @(posedge clk or posedge q_rst) begin
    int unsigned nc;
    if (q_rst) begin
      qwp <= 0; qrp <= 0; qcnt <= 0; qdo <= '0;
    end else begin
      nc = qcnt;
      if (q_enqueue && qcnt < 8) begin
        qmem[qwp] <= q_data_in;
        qwp <= (qwp + 1) % 8;
        nc = nc + 1;
      end
      if (q_dequeue && qcnt > 0) begin
        qdo <= qmem[qrp];
        qrp <= (qrp + 1) % 8;
        nc = nc - 1;
      end
      qcnt <= nc;
    end
  end

  assign q_data_out = qdo;
  assign q_is_empty = force_empty | (qcnt == 0);
  assign q_is_full  = (qcnt == 8);

  // Protocol watch: never both ops, never dequeue empty, never enqueue full
  always @(negedge clk) begin
    if (rst) begin
      if (q_enqueue && q_dequeue) viol++;
      if (q_dequeue && level == 4'd0) viol++;
      if (q_enqueue && level == 4'd8) viol++;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; p0_req = 0; p1_req = 0; c_req = 0; force_empty = 0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Push one byte from p0 and wait (bounded) for its grant
  task automatic p0_push(input logic [7:0] d);
    int waits = 0;
    p0_req = 1; p0_data = d;
    do begin @(negedge clk); waits++; end while (!p0_gnt && waits < 10);
    checks++;
    if (!p0_gnt) begin errors++; $display("FAIL push_timeout got=%0b want=1", p0_gnt); end
    p0_req = 0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({p0_gnt, p1_gnt, c_valid, q_enqueue, q_dequeue, q_peek, err} !== 7'b0) begin
      errors++; $display("FAIL reset_flags got=%b want=0", {p0_gnt, p1_gnt, c_valid, q_enqueue, q_dequeue, q_peek, err});
    end
    checks++;
    if (level !== 4'd0) begin errors++; $display("FAIL reset_level got=%0d want=0", level); end
    checks++;
    if (q_rst !== 1'b1) begin errors++; $display("FAIL reset_q_rst got=%b want=1", q_rst); end
    checks++;
    if ({c_data, q_data_in} !== 16'h0) begin errors++; $display("FAIL reset_data got=%h want=0", {c_data, q_data_in}); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (q_rst !== 1'b0) begin errors++; $display("FAIL q_rst_release got=%b want=0", q_rst); end
  endtask

  task automatic test_p0_writes();
    logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    int waits;
    for (int i = 0; i < 4; i++) begin
      p0_req = 1; p0_data = vals[i]; waits = 0;
      do begin @(negedge clk); waits++; end while (!p0_gnt && waits < 10);
      checks++;
      if (waits !== ((i == 0) ? 1 : 2) || !p0_gnt) begin
        errors++; $display("FAIL wr_spacing[%0d] got=%0d want=%0d", i, waits, (i == 0) ? 1 : 2);
      end
      checks++;
      if (q_enqueue !== 1'b1 || q_data_in !== vals[i] || p1_gnt !== 1'b0) begin
        errors++; $display("FAIL wr_data[%0d] got=%h/%b want=%h/1", i, q_data_in, q_enqueue, vals[i]);
      end
    end
    p0_req = 0;
    @(negedge clk);
    checks++;
    if (level !== 4'd4) begin errors++; $display("FAIL wr_level got=%0d want=4", level); end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL wr_err got=%b want=0", err); end
  endtask

  task automatic test_reads();
    logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    int waits;
    int extra = 0;
    c_req = 1;
    for (int i = 0; i < 4; i++) begin
      waits = 0;
      do begin @(negedge clk); waits++; end while (!c_valid && waits < 12);
      checks++;
      if (waits !== 3 || !c_valid) begin errors++; $display("FAIL rd_spacing[%0d] got=%0d want=3", i, waits); end
      checks++;
      if (c_data !== vals[i]) begin errors++; $display("FAIL rd_data[%0d] got=%h want=%h", i, c_data, vals[i]); end
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (c_valid || q_dequeue) extra++;
    end
    c_req = 0;
    checks++;
    if (extra !== 0) begin errors++; $display("FAIL rd_empty_stall got=%0d want=0", extra); end
    checks++;
    if (level !== 4'd0) begin errors++; $display("FAIL rd_level got=%0d want=0", level); end
  endtask

  task automatic test_round_robin();
    int waits;
    int extra = 0;
    logic exp_p1 = 1'b0;
    logic [7:0] want;
    logic mem_ok = 1'b1;
    do_reset();
    p0_req = 1; p1_req = 1; p0_data = 8'h55; p1_data = 8'h66;
    for (int k = 0; k < 8; k++) begin
      waits = 0;
      do begin @(negedge clk); waits++; end while (!(p0_gnt || p1_gnt) && waits < 10);
      want = 8'h55 + 8'(8'h11 * k);
      checks++;
      if (p1_gnt !== exp_p1 || p0_gnt !== !exp_p1) begin
        errors++; $display("FAIL rr_winner[%0d] got=p0:%b p1:%b want_p1=%b", k, p0_gnt, p1_gnt, exp_p1);
      end
      checks++;
      if (q_data_in !== want || waits !== ((k == 0) ? 1 : 2)) begin
        errors++; $display("FAIL rr_data[%0d] got=%h/%0d want=%h/%0d", k, q_data_in, waits, want, (k == 0) ? 1 : 2);
      end
      if (p0_gnt) p0_data = p0_data + 8'h22;
      if (p1_gnt) p1_data = p1_data + 8'h22;
      exp_p1 = !exp_p1;
    end
    @(negedge clk);
    checks++;
    if (level !== 4'd8) begin errors++; $display("FAIL rr_level got=%0d want=8", level); end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (p0_gnt || p1_gnt || q_enqueue) extra++;
    end
    checks++;
    if (extra !== 0) begin errors++; $display("FAIL full_stall got=%0d want=0", extra); end
    for (int i = 0; i < 8; i++) if (qmem[i] !== 8'(8'h55 + 8'(8'h11 * i))) mem_ok = 1'b0;
    checks++;
    if (mem_ok !== 1'b1) begin errors++; $display("FAIL rr_queue_order got=%h want=55", qmem[0]); end
  endtask

  task automatic test_pop_then_write();
    int waits = 0;
    int early = 0;
    p0_req = 0; p1_req = 1; p1_data = 8'hdd; c_req = 1;
    do begin
      @(negedge clk); waits++;
      if (p1_gnt || q_enqueue) early++;
    end while (!c_valid && waits < 10);
    checks++;
    if (!c_valid || c_data !== 8'h55 || waits !== 3) begin
      errors++; $display("FAIL full_pop got=%h/%0d want=55/3", c_data, waits);
    end
    checks++;
    if (early !== 0 || level !== 4'd7) begin errors++; $display("FAIL read_priority got=%0d/%0d want=0/7", early, level); end
    c_req = 0;
    @(negedge clk);
    checks++;
    if (p1_gnt !== 1'b1 || p0_gnt !== 1'b0 || q_data_in !== 8'hdd) begin
      errors++; $display("FAIL refill_gnt got=%b/%h want=1/dd", p1_gnt, q_data_in);
    end
    p1_req = 0;
    @(negedge clk);
    checks++;
    if (level !== 4'd8) begin errors++; $display("FAIL refill_level got=%0d want=8", level); end
  endtask

  task automatic test_err();
    do_reset();
    p0_push(8'h01); p0_push(8'h02); p0_push(8'h03);
    @(negedge clk);
    checks++;
    if (level !== 4'd3 || err !== 1'b0) begin errors++; $display("FAIL err_pre got=%0d/%b want=3/0", level, err); end
    force_empty = 1;
    repeat (2) @(negedge clk);
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL err_set got=%b want=1", err); end
    force_empty = 0;
    repeat (5) @(negedge clk);
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got=%b want=1", err); end
    do_reset();
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL err_clear got=%b want=0", err); end
  endtask

  task automatic test_reset_mid_read();
    int extra = 0;
    do_reset();
    p0_push(8'ha1); p0_push(8'ha2);
    @(negedge clk);
    c_req = 1;
    @(negedge clk);
    checks++;
    if (q_dequeue !== 1'b1) begin errors++; $display("FAIL mid_in_read got=%b want=1", q_dequeue); end
    rst = 0;
    #1;
    checks++;
    if ({p0_gnt, p1_gnt, c_valid, q_enqueue, q_dequeue, err} !== 6'b0 || level !== 4'd0 || q_rst !== 1'b1) begin
      errors++; $display("FAIL mid_reset_clear got=%b lvl=%0d q_rst=%b want=0/0/1",
                         {p0_gnt, p1_gnt, c_valid, q_enqueue, q_dequeue, err}, level, q_rst);
    end
    c_req = 0;
    @(negedge clk);
    rst = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (c_valid) extra++;
    end
    checks++;
    if (extra !== 0 || level !== 4'd0) begin errors++; $display("FAIL mid_no_valid got=%0d/%0d want=0/0", extra, level); end
    p0_req = 1; p0_data = 8'h5a;
    @(negedge clk);
    checks++;
    if (p0_gnt !== 1'b1) begin errors++; $display("FAIL mid_idle got=%b want=1", p0_gnt); end
    p0_req = 0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_p0_writes();
    test_reads();
    test_round_robin();
    test_pop_then_write();
    test_err();
    test_reset_mid_read();
    checks++;
    if (viol !== 0) begin errors++; $display("FAIL protocol_violations got=%0d want=0", viol); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
